// File: rtl/dphy_lane_deskew_if.sv
// Byte-lane bundle between the D-PHY lane receivers, the deskew block and the CSI-2 parser.
// master drives lanes and parser controls; slave is the deskew block.
interface dphy_lane_deskew_if #(
    parameter int DATA_LANES = 4,
    parameter int MAX_SKEW   = 3
);
    localparam int SKEW_W = (MAX_SKEW + 1 > 2) ? $clog2(MAX_SKEW + 1) : 1;
    localparam int LANE_W = $clog2(DATA_LANES + 1);

    logic                           enable_i;
    logic [LANE_W-1:0]              active_lanes_i;
    logic                           wait_for_sync_i;
    logic                           pkt_done_i;
    logic [DATA_LANES*8-1:0]        byte_data_i;
    logic [DATA_LANES-1:0]          valid_i;
    logic                           pkt_done_o;
    logic [DATA_LANES*8-1:0]        word_o;
    logic                           valid_o;
    logic                           skew_err_o;
    logic [DATA_LANES*SKEW_W-1:0]   lane_skew_o;

    modport master (
        output enable_i, active_lanes_i, wait_for_sync_i, pkt_done_i, byte_data_i, valid_i,
        input  pkt_done_o, word_o, valid_o, skew_err_o, lane_skew_o
    );

    modport slave (
        input  enable_i, active_lanes_i, wait_for_sync_i, pkt_done_i, byte_data_i, valid_i,
        output pkt_done_o, word_o, valid_o, skew_err_o, lane_skew_o
    );
endinterface

// File: rtl/dphy_lane_deskew.sv
// D-PHY lane deskew: aligns up to DATA_LANES byte lanes with MAX_SKEW cycles of skew; latency 2 cycles on the latest lane.
// No backpressure: enable_i freezes delay lines and FSM, output registers keep loading from the held taps.
module dphy_lane_deskew #(
    parameter int DATA_LANES = 4,
    parameter int MAX_SKEW   = 3
) (
    input  logic              byte_clk_i,
    input  logic              rst_i,
    dphy_lane_deskew_if.slave bus
);
    localparam int TAPS   = MAX_SKEW + 1;
    localparam int SKEW_W = (TAPS > 2) ? $clog2(TAPS) : 1;
    localparam int LANE_W = $clog2(DATA_LANES + 1);
    localparam int RUN_W  = $clog2(TAPS + 1);

    typedef enum logic [1:0] {ST_IDLE, ST_ALIGN, ST_LOCKED, ST_DRAIN} state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [7:0]              r_tap_dat [DATA_LANES][TAPS];
    logic [DATA_LANES-1:0]   r_d1_vld;
    logic [DATA_LANES-1:0]   r_mask;
    logic [RUN_W-1:0]        r_run     [DATA_LANES];
    logic [SKEW_W-1:0]       r_sel     [DATA_LANES];
    logic [DATA_LANES*8-1:0] r_word;
    logic                    r_valid;
    logic                    r_skew_err;

    logic [DATA_LANES-1:0]   w_vld;
    logic [DATA_LANES-1:0]   w_mask_nxt;
    logic [LANE_W-1:0]       w_act_n;
    logic [RUN_W-1:0]        w_run_nxt [DATA_LANES];
    logic [SKEW_W-1:0]       w_tap_sel [DATA_LANES];
    logic                    w_all_vld;
    logic                    w_bad;
    logic                    w_lock;
    logic                    w_err;

    assign w_vld = r_d1_vld & r_mask;

    // Out-of-range lane counts fall back to every physical lane.
    always_comb begin
        w_act_n = bus.active_lanes_i;
        if (bus.active_lanes_i == '0 || int'(bus.active_lanes_i) > DATA_LANES)
            w_act_n = LANE_W'(DATA_LANES);
        for (int i = 0; i < DATA_LANES; i++)
            w_mask_nxt[i] = (i < int'(w_act_n));
    end

    always_comb begin
        w_all_vld = 1'b1;
        w_bad     = 1'b0;
        for (int i = 0; i < DATA_LANES; i++) begin
            w_run_nxt[i] = '0;
            w_tap_sel[i] = '0;
            if (w_vld[i]) begin
                w_run_nxt[i] = (r_run[i] == RUN_W'(TAPS)) ? r_run[i] : r_run[i] + RUN_W'(1);
                w_tap_sel[i] = SKEW_W'(w_run_nxt[i] - RUN_W'(1));
            end
            if (r_mask[i]) begin
                if (!w_vld[i])
                    w_all_vld = 1'b0;
                if (w_run_nxt[i] == RUN_W'(TAPS) || (!w_vld[i] && r_run[i] != '0))
                    w_bad = 1'b1;
            end
        end
    end

    always_ff @(posedge byte_clk_i) begin
        if (rst_i)
            r_state <= ST_IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_lock      = 1'b0;
        w_err       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.enable_i && bus.wait_for_sync_i)
                    w_state_nxt = ST_ALIGN;
            end
            ST_ALIGN: begin
                if (bus.enable_i && w_all_vld) begin
                    w_lock      = 1'b1;
                    w_state_nxt = ST_LOCKED;
                end else if (bus.enable_i && w_bad) begin
                    w_err       = 1'b1;
                    w_state_nxt = ST_DRAIN;
                end else if (!bus.wait_for_sync_i || bus.pkt_done_i) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_LOCKED: begin
                if (bus.pkt_done_i)
                    w_state_nxt = ST_IDLE;
            end
            ST_DRAIN: begin
                if (bus.enable_i && w_vld == '0)
                    w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge byte_clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < DATA_LANES; i++) begin
                for (int k = 0; k < TAPS; k++)
                    r_tap_dat[i][k] <= '0;
                r_run[i] <= '0;
                r_sel[i] <= '0;
            end
            r_d1_vld   <= '0;
            r_mask     <= '1;
            r_word     <= '0;
            r_valid    <= 1'b0;
            r_skew_err <= 1'b0;
        end else begin
            if (bus.enable_i) begin
                for (int i = 0; i < DATA_LANES; i++) begin
                    r_tap_dat[i][0] <= bus.byte_data_i[i*8 +: 8];
                    for (int k = 1; k < TAPS; k++)
                        r_tap_dat[i][k] <= r_tap_dat[i][k-1];
                    r_run[i] <= (r_state == ST_ALIGN) ? w_run_nxt[i] : '0;
                end
                r_d1_vld <= bus.valid_i;
                if (r_state == ST_IDLE)
                    r_mask <= w_mask_nxt;
            end
            r_skew_err <= w_err;
            r_valid    <= (w_state_nxt == ST_LOCKED);
            // Lock edge picks each lane's tap from its run length so beat 0 is byte 0 everywhere.
            if (w_lock) begin
                for (int i = 0; i < DATA_LANES; i++) begin
                    r_sel[i]          <= w_tap_sel[i];
                    r_word[i*8 +: 8]  <= r_mask[i] ? r_tap_dat[i][w_tap_sel[i]] : 8'h00;
                end
            end else if (r_state == ST_LOCKED) begin
                for (int i = 0; i < DATA_LANES; i++)
                    r_word[i*8 +: 8] <= r_mask[i] ? r_tap_dat[i][r_sel[i]] : 8'h00;
            end
        end
    end

    always_comb begin
        for (int i = 0; i < DATA_LANES; i++)
            bus.lane_skew_o[i*SKEW_W +: SKEW_W] = r_sel[i];
    end

    assign bus.word_o     = r_word;
    assign bus.valid_o    = r_valid;
    assign bus.skew_err_o = r_skew_err;
    assign bus.pkt_done_o = bus.pkt_done_i | r_skew_err;
endmodule

// File: tb/tb_dphy_lane_deskew.sv
// Scoreboard bench for dphy_lane_deskew: expected words are queued as lane bytes are driven
// and popped on every valid_o beat; the monitor closes each packet with pkt_done_i.
module tb_dphy_lane_deskew;
    localparam int DL = 4;
    localparam int MS = 3;
    localparam int SW = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    dphy_lane_deskew_if #(.DATA_LANES(DL), .MAX_SKEW(MS)) bus ();

    dphy_lane_deskew #(.DATA_LANES(DL), .MAX_SKEW(MS)) dut (
        .byte_clk_i (clk),
        .rst_i      (rst),
        .bus        (bus)
    );

    int n_cmp    = 0;
    int n_bad    = 0;
    int beat_cnt = 0;
    int pkt_len  = 1000;
    int err_cnt  = 0;
    int act      = 4;
    int off [DL];
    logic [31:0] exp_q [$];

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int act_eff(input int a);
        return (a == 0 || a > DL) ? DL : a;
    endfunction

    // Monitor: pops the scoreboard on each beat and pulses pkt_done_i on the last one.
    initial begin
        bus.pkt_done_i = 1'b0;
        forever begin
            @(negedge clk);
            if (bus.pkt_done_i)
                bus.pkt_done_i = 1'b0;
            if (bus.skew_err_o) begin
                err_cnt++;
                check_eq("pkt_done_o_on_err", bus.pkt_done_o, 1);
            end
            if (bus.valid_o && !rst) begin
                if (exp_q.size() == 0) begin
                    check_eq("extra_beat", bus.valid_o, 0);
                end else begin
                    check_eq("word", bus.word_o, exp_q.pop_front());
                    beat_cnt++;
                    if (beat_cnt == pkt_len) begin
                        bus.pkt_done_i = 1'b1;
                        #1;
                        check_eq("pkt_done_o", bus.pkt_done_o, 1);
                    end
                end
            end
        end
    end

    task automatic idle_lanes();
        bus.valid_i     = '0;
        bus.byte_data_i = '0;
    endtask

    task automatic run_pkt(input string name, input int len, input int stall_at, input int rst_beat);
        int ae;
        int maxoff;
        int n;
        logic [31:0] d;
        logic [31:0] w;
        logic [DL-1:0] v;
        logic [DL*SW-1:0] skew_exp;
        ae       = act_eff(act);
        maxoff   = 0;
        skew_exp = '0;
        for (int i = 0; i < ae; i++)
            if (off[i] > maxoff) maxoff = off[i];
        for (int i = 0; i < ae; i++)
            skew_exp[i*SW +: SW] = SW'(maxoff - off[i]);
        beat_cnt = 0;
        err_cnt  = 0;
        pkt_len  = (rst_beat >= 0) ? 1000 : len;
        bus.active_lanes_i  = 3'(act);
        bus.wait_for_sync_i = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        for (int c = 0; c < len + maxoff; c++) begin
            for (int i = 0; i < DL; i++) begin
                n = c - off[i];
                d[i*8 +: 8] = 8'($urandom);
                v[i]        = 1'($urandom);
                if (i < ae) begin
                    v[i] = (n >= 0 && n < len);
                    if (v[i]) d[i*8 +: 8] = 8'(16 * i + n);
                end
            end
            bus.byte_data_i = d;
            bus.valid_i     = v;
            if (c >= maxoff) begin
                w = '0;
                for (int i = 0; i < ae; i++)
                    w[i*8 +: 8] = 8'(16 * i + c - maxoff);
                exp_q.push_back(w);
            end
            if (c == stall_at) begin
                bus.enable_i = 1'b0;
                repeat (2) @(posedge clk);
                #1;
                bus.enable_i = 1'b1;
            end
            @(posedge clk);
            #1;
            if (rst_beat >= 0 && beat_cnt >= rst_beat) begin
                rst = 1'b1;
                @(posedge clk);
                #1;
                check_eq({name, "_rst_valid"}, bus.valid_o, 0);
                check_eq({name, "_rst_word"}, bus.word_o, 0);
                check_eq({name, "_rst_err"}, bus.skew_err_o, 0);
                check_eq({name, "_rst_skew"}, bus.lane_skew_o, 0);
                check_eq({name, "_rst_done"}, bus.pkt_done_o, 0);
                rst = 1'b0;
                exp_q.delete();
                idle_lanes();
                bus.wait_for_sync_i = 1'b0;
                repeat (3) @(posedge clk);
                #1;
                return;
            end
        end
        idle_lanes();
        for (int k = 0; k < 40 && beat_cnt < len; k++)
            @(posedge clk);
        repeat (2) @(posedge clk);
        #1;
        check_eq({name, "_beats"}, beat_cnt, len);
        check_eq({name, "_q_left"}, exp_q.size(), 0);
        check_eq({name, "_lane_skew"}, bus.lane_skew_o, skew_exp);
        check_eq({name, "_no_err"}, err_cnt, 0);
        check_eq({name, "_valid_low"}, bus.valid_o, 0);
        bus.wait_for_sync_i = 1'b0;
        exp_q.delete();
        repeat (3) @(posedge clk);
        #1;
    endtask

    // Lane 0 alone: either runs past MAX_SKEW or drops out before the others arrive.
    task automatic run_err(input string name, input int lane0_len);
        act      = 4;
        beat_cnt = 0;
        err_cnt  = 0;
        pkt_len  = 1000;
        bus.active_lanes_i  = 3'(act);
        bus.wait_for_sync_i = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        for (int c = 0; c < lane0_len; c++) begin
            bus.valid_i     = 4'b0001;
            bus.byte_data_i = 32'(8'(c));
            @(posedge clk);
            #1;
        end
        idle_lanes();
        repeat (8) @(posedge clk);
        #1;
        check_eq({name, "_err_pulses"}, err_cnt, 1);
        check_eq({name, "_no_beats"}, beat_cnt, 0);
        check_eq({name, "_valid_low"}, bus.valid_o, 0);
        bus.wait_for_sync_i = 1'b0;
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst                 = 1'b1;
        bus.enable_i        = 1'b1;
        bus.active_lanes_i  = 3'd4;
        bus.wait_for_sync_i = 1'b0;
        idle_lanes();
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check_eq("reset_valid", bus.valid_o, 0);
        check_eq("reset_word", bus.word_o, 0);
        check_eq("reset_err", bus.skew_err_o, 0);
        check_eq("reset_skew", bus.lane_skew_o, 0);
        check_eq("reset_done", bus.pkt_done_o, 0);

        act = 4; off = '{0, 1, 2, 0};
        run_pkt("skew_mix", 4, -1, -1);
        act = 4; off = '{0, 0, 0, 0};
        run_pkt("aligned8", 8, -1, -1);
        run_err("lone_lane", 4);
        act = 2; off = '{0, 3, 0, 0};
        run_pkt("two_lanes", 5, -1, -1);
        act = 4; off = '{0, 2, 0, 0};
        run_pkt("stall", 4, 1, -1);
        run_err("dropout", 2);
        act = 1; off = '{0, 0, 0, 0};
        run_pkt("one_lane", 3, -1, -1);
        act = 0; off = '{1, 0, 0, 1};
        run_pkt("zero_is_all", 3, -1, -1);
        act = 4; off = '{0, 0, 0, 0};
        run_pkt("mid_reset", 8, -1, 2);
        act = 4; off = '{3, 0, 1, 2};
        run_pkt("after_reset", 4, -1, -1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
